led_mode_ctrl: RTL and testbench
================================

# led_mode_ctrl

Parametrised LED mode controller that replaces the fixed two-mode LED multiplexing in the board top level with up to four selectable display modes: switch mirror, cursor toggler, up/down counter and timed chaser. It takes single-cycle button pulses that are already debounced and edge-detected upstream. It owns all per-mode state and drives the board LEDs directly.

## Interface
- `NumLeds`, default 4: number of LEDs; legal range 2..16.
- `NumModes`, default 4: number of reachable modes; legal range 1..4.
- `TickCycles`, default 12500000: clock cycles per chaser step; legal minimum 2.
- `ModeW` (localparam): max(1, $clog2(NumModes)).

Ports:
- `clk_i`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `mode_i`, input, 1: single-cycle pulse that advances the mode.
- `next_i`, input, 1: single-cycle pulse, "next/up".
- `prev_i`, input, 1: single-cycle pulse, "prev/down".
- `toggle_i`, input, 1: single-cycle pulse, "toggle/action".
- `switch_i`, input, NumLeds: slide switch levels.
- `led_o`, output, NumLeds: LED drive.
- `mode_o`, output, ModeW: current mode index (registered).

## Operation
- **Mode register** (reset 0):
  - A `mode_i` pulse sets mode to mode+1, wrapping from NumModes-1 to 0.
  - With NumModes=1, `mode_i` is ignored.
- **Mode isolation:**
  - `next_i`, `prev_i` and `toggle_i` act only on the mode active in the current cycle (mode_q).
  - These pulses are ignored by inactive modes.
  - Per-mode state persists across mode changes and is not cleared on exit or entry.
- **Mode 0, SWITCH:** `led_o` = `switch_i`, combinational.
- **Mode 1, TOGGLE:**
  - State: cursor (0..NumLeds-1, reset 0) and pattern (reset 0). `led_o` = pattern.
  - `next_i` sets cursor to cursor+1, wrapping to 0. `prev_i` sets cursor to cursor-1, wrapping to NumLeds-1.
  - `next_i` and `prev_i` in the same cycle: cursor unchanged.
  - `toggle_i` inverts pattern[cursor], using the cursor value before any same-cycle move.
- **Mode 2, COUNT:**
  - State: NumLeds-bit counter (reset 0). `led_o` = counter.
  - `next_i` increments mod 2^NumLeds; `prev_i` decrements mod 2^NumLeds.
  - `next_i` and `prev_i` together: no change.
  - `toggle_i` clears the counter to 0 and takes priority over `next_i`/`prev_i`.
- **Mode 3, CHASE:**
  - State: one-hot position (reset bit 0), direction (reset up, toward MSB), run flag (reset 1), prescaler (reset 0). `led_o` = position.
  - `toggle_i` inverts the run flag. `next_i` sets direction up. `prev_i` sets direction down.
  - `next_i` and `prev_i` together: direction unchanged.
  - Prescaler behaviour:
    - Counts 0..TickCycles-1 only while mode 3 is active and running.
    - Holds its value while paused.
    - Forced to 0 whenever mode_q != 3.
  - Step: in a cycle where running and prescaler = TickCycles-1, the prescaler wraps to 0 and position rotates one place in the current direction. Wrap-around: MSB to bit 0 going up, bit 0 to MSB going down.
  - A direction change and a step in the same cycle: the step uses the old direction.
- **Unreachable modes:**
  - Modes with index >= NumModes are never entered, and their state may be optimised away.
  - `led_o` = 0 if mode_q is ever out of range.

## Timing
- All state is in registers updated on the rising edge of `clk_i`.
- Pulse at cycle t: the register changes at the edge ending cycle t, and `led_o`/`mode_o` reflect it in cycle t+1 (latency 1).
- Mode 0 `switch_i` to `led_o`: combinational, 0 cycles.
- Simultaneous `mode_i` with another pulse: the other pulse applies to the old mode; the new mode is visible from t+1.
- Reset:
  - `rst_n` low at an edge returns every register to its reset value, regardless of pulses.
  - Reset outputs: `mode_o` = 0 and `led_o` = `switch_i`.
  - A reset in the middle of a chase step discards the pending step.
- Chaser period: exactly TickCycles cycles between position changes while running uninterrupted in mode 3.

## Test plan
- **Reset and mode cycling** (NumLeds=4, NumModes=4): after reset, `mode_o`=0 and `led_o` tracks `switch_i`=4'b1010 in the same cycle. Apply 4 `mode_i` pulses: `mode_o` reads 1, 2, 3, 0, each one cycle after its pulse.
- **Toggle mode:**
  - In mode 1: `prev_i` moves cursor to 3, `toggle_i` gives `led_o`=4'b1000, `next_i` twice moves cursor to 1, `toggle_i` gives 4'b1010.
  - `next_i`+`toggle_i` in the same cycle with cursor 1 gives 4'b1000 and cursor 2.
- **Count mode:**
  - In mode 2: `prev_i` from 0 gives 4'b1111. `next_i` then gives 0. Three `next_i` give 3.
  - `toggle_i`+`next_i` together gives 0.
  - Leave to mode 3 and return to mode 2: value is retained.
- **Chase mode** (TickCycles=4):
  - In mode 3, `led_o` steps 0001, 0010, 0100, 1000, 0001 at exactly 4-cycle intervals.
  - `prev_i` reverses the direction to 1000.
  - `toggle_i` freezes `led_o` for 20 cycles; a second `toggle_i` resumes stepping with the prescaler continuing from its held value.
- **Isolation:** in mode 0, pulse `next_i`, `prev_i` and `toggle_i`. Entering modes 1–3 shows the unchanged prior state, and the chaser prescaler is 0 on entry.
- **Reset mid-operation and NumModes=2:**
  - Assert `rst_n` low for 1 cycle with counter=5 in mode 2 while `next_i` is high: all state is at reset values afterwards.
  - With NumModes=2, `mode_i` pulses give `mode_o` 1, 0, 1.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// LED mode controller: switch mirror, cursor toggler, up/down counter and timed chaser,
// selected by a wrapping mode register and driven by pre-conditioned single-cycle button pulses.
module led_mode_ctrl #(
    parameter int NumLeds    = 4,
    parameter int NumModes   = 4,
    parameter int TickCycles = 12500000,
    localparam int ModeW     = (NumModes > 1) ? $clog2(NumModes) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               mode_i,
    input  logic               next_i,
    input  logic               prev_i,
    input  logic               toggle_i,
    input  logic [NumLeds-1:0] switch_i,
    output logic [NumLeds-1:0] led_o,
    output logic [ModeW-1:0]   mode_o
);

    localparam int CurW = $clog2(NumLeds);
    localparam int PreW = $clog2(TickCycles);

    localparam logic [ModeW-1:0] ModeMax = ModeW'(NumModes - 1);
    localparam logic [CurW-1:0]  CurMax  = CurW'(NumLeds - 1);
    localparam logic [PreW-1:0]  PreMax  = PreW'(TickCycles - 1);

    localparam logic [31:0] ModeSwitch = 32'd0;
    localparam logic [31:0] ModeToggle = 32'd1;
    localparam logic [31:0] ModeCount  = 32'd2;
    localparam logic [31:0] ModeChase  = 32'd3;

    function automatic logic [NumLeds-1:0] rot_up(input logic [NumLeds-1:0] v);
        return {v[NumLeds-2:0], v[NumLeds-1]};
    endfunction

    function automatic logic [NumLeds-1:0] rot_down(input logic [NumLeds-1:0] v);
        return {v[0], v[NumLeds-1:1]};
    endfunction

    // ---------------- mode FSM ----------------
    logic [ModeW-1:0] mode_r;
    logic [ModeW-1:0] mode_s;
    logic [31:0]      mode_ext_s;
    logic             act_tog_s;
    logic             act_cnt_s;
    logic             act_chase_s;

    // Mode state register
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            mode_r <= {ModeW{1'b0}};
        end else begin
            mode_r <= mode_s;
        end
    end

    // Mode next-state: advance on a pulse, wrap at the last reachable mode
    always_comb begin
        mode_s = mode_r;
        if (mode_i && (NumModes > 1)) begin
            if (mode_r == ModeMax) begin
                mode_s = {ModeW{1'b0}};
            end else begin
                mode_s = mode_r + ModeW'(1'b1);
            end
        end else begin
            mode_s = mode_r;
        end
    end

    // Widened mode index so per-mode decodes work for any ModeW
    always_comb begin
        mode_ext_s  = 32'(mode_r);
        act_tog_s   = (NumModes > 1) && (mode_ext_s == ModeToggle);
        act_cnt_s   = (NumModes > 2) && (mode_ext_s == ModeCount);
        act_chase_s = (NumModes > 3) && (mode_ext_s == ModeChase);
    end

    assign mode_o = mode_r;

    // ---------------- toggle mode ----------------
    logic [CurW-1:0]    cursor_r;
    logic [CurW-1:0]    cursor_s;
    logic [NumLeds-1:0] pattern_r;
    logic [NumLeds-1:0] pattern_s;

    // Toggle next-state: the toggle uses the cursor before any same-cycle move
    always_comb begin
        cursor_s  = cursor_r;
        pattern_s = pattern_r;
        if (act_tog_s) begin
            if (toggle_i) begin
                pattern_s = pattern_r ^ (NumLeds'(1'b1) << cursor_r);
            end else begin
                pattern_s = pattern_r;
            end
            if (next_i && !prev_i) begin
                cursor_s = (cursor_r == CurMax) ? {CurW{1'b0}} : cursor_r + CurW'(1'b1);
            end else if (prev_i && !next_i) begin
                cursor_s = (cursor_r == {CurW{1'b0}}) ? CurMax : cursor_r - CurW'(1'b1);
            end else begin
                cursor_s = cursor_r;
            end
        end else begin
            cursor_s  = cursor_r;
            pattern_s = pattern_r;
        end
    end

    // ---------------- count mode ----------------
    logic [NumLeds-1:0] cnt_r;
    logic [NumLeds-1:0] cnt_s;

    // Counter next-state: clear wins over up/down; up+down cancel
    always_comb begin
        cnt_s = cnt_r;
        if (act_cnt_s) begin
            if (toggle_i) begin
                cnt_s = {NumLeds{1'b0}};
            end else if (next_i && !prev_i) begin
                cnt_s = cnt_r + NumLeds'(1'b1);
            end else if (prev_i && !next_i) begin
                cnt_s = cnt_r - NumLeds'(1'b1);
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // ---------------- chase mode ----------------
    logic [NumLeds-1:0] pos_r;
    logic [NumLeds-1:0] pos_s;
    logic               dir_up_r;
    logic               dir_up_s;
    logic               run_r;
    logic               run_s;
    logic [PreW-1:0]    presc_r;
    logic [PreW-1:0]    presc_s;
    logic               step_s;

    // Chaser next-state: steps use the registered direction, so a same-cycle reversal applies later
    always_comb begin
        step_s   = act_chase_s && run_r && (presc_r == PreMax);
        pos_s    = pos_r;
        dir_up_s = dir_up_r;
        run_s    = run_r;
        presc_s  = presc_r;
        if (!act_chase_s) begin
            presc_s = {PreW{1'b0}};
        end else if (run_r) begin
            presc_s = step_s ? {PreW{1'b0}} : presc_r + PreW'(1'b1);
        end else begin
            presc_s = presc_r;
        end
        if (step_s) begin
            pos_s = dir_up_r ? rot_up(pos_r) : rot_down(pos_r);
        end else begin
            pos_s = pos_r;
        end
        if (act_chase_s) begin
            run_s = toggle_i ? ~run_r : run_r;
            if (next_i && !prev_i) begin
                dir_up_s = 1'b1;
            end else if (prev_i && !next_i) begin
                dir_up_s = 1'b0;
            end else begin
                dir_up_s = dir_up_r;
            end
        end else begin
            run_s    = run_r;
            dir_up_s = dir_up_r;
        end
    end

    // Per-mode state registers; they persist across mode changes
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cursor_r  <= {CurW{1'b0}};
            pattern_r <= {NumLeds{1'b0}};
            cnt_r     <= {NumLeds{1'b0}};
            pos_r     <= NumLeds'(1'b1);
            dir_up_r  <= 1'b1;
            run_r     <= 1'b1;
            presc_r   <= {PreW{1'b0}};
        end else begin
            cursor_r  <= cursor_s;
            pattern_r <= pattern_s;
            cnt_r     <= cnt_s;
            pos_r     <= pos_s;
            dir_up_r  <= dir_up_s;
            run_r     <= run_s;
            presc_r   <= presc_s;
        end
    end

    // LED output mux; switch mirror stays combinational, unreachable modes go dark
    always_comb begin
        led_o = {NumLeds{1'b0}};
        case (mode_ext_s)
            ModeSwitch: led_o = switch_i;
            ModeToggle: led_o = (NumModes > 1) ? pattern_r : {NumLeds{1'b0}};
            ModeCount:  led_o = (NumModes > 2) ? cnt_r : {NumLeds{1'b0}};
            ModeChase:  led_o = (NumModes > 3) ? pos_r : {NumLeds{1'b0}};
            default:    led_o = {NumLeds{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl: table of single-cycle pulses plus hand sequences
// for chaser timing, isolation, mid-operation reset and a two-mode build.
module tb_led_mode_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic       mode_i, next_i, prev_i, toggle_i;
    logic [3:0] switch_i;
    logic [3:0] led_o;
    logic [1:0] mode_o;
    logic       mode2_i;
    logic [3:0] led2_o;
    logic [0:0] mode2_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    led_mode_ctrl #(.NumLeds(4), .NumModes(4), .TickCycles(4)) u_dut (
        .clk_i(clk_i), .rst_n(rst_n), .mode_i(mode_i), .next_i(next_i),
        .prev_i(prev_i), .toggle_i(toggle_i), .switch_i(switch_i),
        .led_o(led_o), .mode_o(mode_o)
    );

    led_mode_ctrl #(.NumLeds(4), .NumModes(2), .TickCycles(4)) u_dut2 (
        .clk_i(clk_i), .rst_n(rst_n), .mode_i(mode2_i), .next_i(1'b0),
        .prev_i(1'b0), .toggle_i(1'b0), .switch_i(switch_i),
        .led_o(led2_o), .mode_o(mode2_o)
    );

    typedef struct {
        logic       m;
        logic       n;
        logic       p;
        logic       t;
        logic [3:0] led;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pulse(input logic m, input logic n, input logic p, input logic t);
        mode_i = m; next_i = n; prev_i = p; toggle_i = t;
        @(posedge clk_i);
        #1;
        mode_i = 1'b0; next_i = 1'b0; prev_i = 1'b0; toggle_i = 1'b0;
    endtask

    task automatic wait_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_chk(input string name, input logic m, input logic n, input logic p,
                             input logic t, input logic [3:0] led, input logic [1:0] mode);
        pulse(m, n, p, t);
        check({name, "_led"}, 8'(led_o), 8'(led));
        check({name, "_mode"}, 8'(mode_o), 8'(mode));
    endtask

    task automatic expect_step(input string name, input int hold,
                               input logic [3:0] old_v, input logic [3:0] new_v);
        for (int i = 0; i < hold; i++) begin
            wait_cyc();
            check({name, "_hold"}, 8'(led_o), 8'(old_v));
        end
        wait_cyc();
        check({name, "_step"}, 8'(led_o), 8'(new_v));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd3};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 2'd2};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd2};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd2};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 2'd2};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 2'd2};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd2};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd2};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd3};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'd0};
        vecs[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd1};
        vecs[27] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd2};
        vecs[28] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 2'd2};

        rst_n = 1'b0; mode_i = 1'b0; next_i = 1'b0; prev_i = 1'b0; toggle_i = 1'b0;
        mode2_i = 1'b0; switch_i = 4'b1010;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        check("reset_mode", 8'(mode_o), 8'd0);
        check("reset_led", 8'(led_o), 8'b1010);
        check("reset_mode2", 8'(mode2_o), 8'd0);
        switch_i = 4'b0110;
        #1;
        check("switch_comb", 8'(led_o), 8'b0110);
        switch_i = 4'b1010;
        #1;

        for (int i = 0; i < 29; i++) begin
            pulse(vecs[i].m, vecs[i].n, vecs[i].p, vecs[i].t);
            check($sformatf("vec%0d_led", i), 8'(led_o), 8'(vecs[i].led));
            check($sformatf("vec%0d_mode", i), 8'(mode_o), 8'(vecs[i].mode));
        end

        // Chaser: exact 4-cycle period, reversal, pause and resume from the held prescaler
        pulse_chk("chase_enter", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd3);
        expect_step("chase1", 3, 4'b0001, 4'b0010);
        expect_step("chase2", 3, 4'b0010, 4'b0100);
        expect_step("chase3", 3, 4'b0100, 4'b1000);
        expect_step("chase4", 3, 4'b1000, 4'b0001);
        pulse_chk("chase_rev", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd3);
        expect_step("chase_down", 2, 4'b0001, 4'b1000);
        wait_cyc();
        check("chase_pre_pause", 8'(led_o), 8'b1000);
        pulse_chk("chase_pause", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3);
        for (int i = 0; i < 20; i++) begin
            wait_cyc();
            check("chase_frozen", 8'(led_o), 8'b1000);
        end
        pulse_chk("chase_resume", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3);
        expect_step("chase_held_presc", 1, 4'b1000, 4'b0100);

        // Isolation: pulses in mode 0 leave every other mode untouched
        pulse_chk("iso_m0", 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'd0);
        pulse_chk("iso_next", 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 2'd0);
        pulse_chk("iso_prev", 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 2'd0);
        pulse_chk("iso_tog", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 2'd0);
        pulse_chk("iso_all", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 2'd0);
        pulse_chk("iso_m1", 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd1);
        pulse_chk("iso_cursor", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1);
        pulse_chk("iso_m2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd2);
        pulse_chk("iso_m3", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd3);
        expect_step("iso_presc0", 3, 4'b0100, 4'b0010);

        // Reset with counter at 5 and next_i high
        pulse_chk("rst_m0", 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'd0);
        pulse_chk("rst_m1", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);
        pulse_chk("rst_m2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd2);
        pulse_chk("rst_c4", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 2'd2);
        pulse_chk("rst_c5", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 2'd2);
        next_i = 1'b1;
        rst_n  = 1'b0;
        @(posedge clk_i);
        #1;
        next_i = 1'b0;
        rst_n  = 1'b1;
        check("mid_rst_mode", 8'(mode_o), 8'd0);
        check("mid_rst_led", 8'(led_o), 8'b1010);
        pulse_chk("post_rst_pat", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);
        pulse_chk("post_rst_cur", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd1);
        pulse_chk("post_rst_cnt", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2);
        pulse_chk("post_rst_pos", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd3);
        expect_step("post_rst_chase", 3, 4'b0001, 4'b0010);

        // Two-mode build wraps 0 -> 1 -> 0 -> 1
        for (int i = 0; i < 3; i++) begin
            mode2_i = 1'b1;
            @(posedge clk_i);
            #1;
            mode2_i = 1'b0;
            check($sformatf("nm2_mode%0d", i), 8'(mode2_o), (i == 1) ? 8'd0 : 8'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
